// File: rtl/vram_swap_if.sv
// vram_swap_if -- signal bundle between the swap controller and its
// neighbours (CPU register block, video timing generator, VRAM).
//
// Signal semantics (there is no valid/ready pair on this bundle):
//   vblank_start : one-cycle pulse, first cycle of vblank.
//   sync_req     : one-cycle pulse, CPU asks for a swap at the next vblank.
//   auto_swap_en : level, request a swap at every vblank_start.
//   cpu_wr_busy  : level, CPU writer still has a write in flight.
//   swap         : one-cycle strobe to the VRAM bank toggle.
//   cpu_wr_block : level, CPU writer must not start new VRAM writes.
//   sync_pending : level, a request is latched and not yet served.
//   sync_done    : one-cycle pulse, the cycle after swap.
//   missed_cnt   : saturating count of windows that expired unserved.
//
// Modports:
//   master : the side that drives the requests/timing (CPU block, bench).
//   slave  : the swap controller.
interface vram_swap_if #(
   parameter int MISS_W = 8
);
   logic              vblank_start;
   logic              sync_req;
   logic              auto_swap_en;
   logic              cpu_wr_busy;
   logic              swap;
   logic              cpu_wr_block;
   logic              sync_pending;
   logic              sync_done;
   logic [MISS_W-1:0] missed_cnt;

   modport master (
      output vblank_start, sync_req, auto_swap_en, cpu_wr_busy,
      input  swap, cpu_wr_block, sync_pending, sync_done, missed_cnt
   );

   modport slave (
      input  vblank_start, sync_req, auto_swap_en, cpu_wr_busy,
      output swap, cpu_wr_block, sync_pending, sync_done, missed_cnt
   );
endinterface

// File: rtl/vram_swap_ctrl.sv
// vram_swap_ctrl -- issues the one-cycle VRAM bank swap strobe.
//
// A swap request (CPU sync_req, or auto_swap_en at vblank_start) is served
// inside a bounded window after vblank_start, only once the CPU write path
// has drained. CPU writes are fenced from the window start until
// SETTLE_CYCLES cycles after the swap.
//
// Ports:
//   clk       : system clock
//   rst_n     : asynchronous active-low reset
//   bus       : vram_swap_if.slave (requests, timing, swap, fence, status)
//   state_dbg : current FSM state (0 IDLE, 1 ARMED, 2 WINDOW, 3 SWAP, 4 SETTLE)
module vram_swap_ctrl #(
   parameter int WINDOW_CYCLES = 64,
   parameter int SETTLE_CYCLES = 4,
   parameter int MISS_W        = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   vram_swap_if.slave     bus,
   output logic [2:0]     state_dbg
);

   localparam int WIN_W = $clog2(WINDOW_CYCLES + 1);
   localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WINDOW_CYCLES - 1);
   localparam logic [SET_W-1:0] SET_LAST = SET_W'(SETTLE_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      ARMED  = 3'd1,
      WINDOW = 3'd2,
      SWAP   = 3'd3,
      SETTLE = 3'd4
   } state_t;

   state_t            state_q, state_d;
   logic [WIN_W-1:0]  win_cnt;
   logic [SET_W-1:0]  set_cnt;
   logic              sticky_q;
   logic              block_q;
   logic [MISS_W-1:0] missed_q;

   logic settle_last;
   logic win_last;
   logic win_expire;
   logic sticky_set;

   assign settle_last = (set_cnt == SET_LAST);
   assign win_last    = (win_cnt == WIN_LAST);
   assign win_expire  = (state_q == WINDOW) && bus.cpu_wr_busy && win_last;

   // A request seen while the swap is in progress is remembered so the
   // controller re-arms on exit instead of dropping it. auto_swap_en only
   // counts here when a vblank actually lands inside SETTLE.
   assign sticky_set = (((state_q == SWAP) || (state_q == SETTLE)) && bus.sync_req)
                     || ((state_q == SETTLE) && bus.auto_swap_en && bus.vblank_start);

   // State register and counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         win_cnt  <= '0;
         set_cnt  <= '0;
         sticky_q <= 1'b0;
         block_q  <= 1'b0;
         missed_q <= '0;
      end else begin
         state_q <= state_d;
         // Counters sit at zero outside their state, so entry loads 0.
         win_cnt <= (state_q == WINDOW) ? win_cnt + 1'b1 : '0;
         set_cnt <= (state_q == SETTLE) ? set_cnt + 1'b1 : '0;
         if ((state_q == SETTLE) && settle_last)
            sticky_q <= 1'b0;
         else if (sticky_set)
            sticky_q <= 1'b1;
         // Fence follows the next state so it is registered yet aligned
         // with the WINDOW/SWAP/SETTLE cycles.
         block_q <= (state_d == WINDOW) || (state_d == SWAP) || (state_d == SETTLE);
         if (win_expire && (missed_q != {MISS_W{1'b1}}))
            missed_q <= missed_q + 1'b1;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (bus.vblank_start && (bus.auto_swap_en || bus.sync_req))
               state_d = WINDOW;
            else if (bus.sync_req)
               state_d = ARMED;
         end
         ARMED: begin
            if (bus.vblank_start)
               state_d = WINDOW;
         end
         WINDOW: begin
            if (!bus.cpu_wr_busy)
               state_d = SWAP;
            else if (win_last)
               state_d = ARMED;
         end
         SWAP:   state_d = SETTLE;
         SETTLE: begin
            if (settle_last)
               state_d = (sticky_q || sticky_set) ? ARMED : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Outputs: swap/sync_done/sync_pending decode state only.
   always_comb begin
      bus.swap         = 1'b0;
      bus.sync_done    = 1'b0;
      bus.sync_pending = 1'b0;
      bus.cpu_wr_block = block_q;
      bus.missed_cnt   = missed_q;
      state_dbg        = state_q;
      case (state_q)
         ARMED:   bus.sync_pending = 1'b1;
         WINDOW:  bus.sync_pending = 1'b1;
         SWAP:    bus.swap         = 1'b1;
         SETTLE:  bus.sync_done    = (set_cnt == '0);
         default: ;
      endcase
   end

endmodule

// File: tb/tb_vram_swap_ctrl.sv
// tb_vram_swap_ctrl -- directed bench for vram_swap_ctrl with default
// parameters (WINDOW_CYCLES=64, SETTLE_CYCLES=4, MISS_W=8).
module tb_vram_swap_ctrl;

   localparam logic [31:0] S_IDLE   = 32'd0;
   localparam logic [31:0] S_ARMED  = 32'd1;
   localparam logic [31:0] S_WINDOW = 32'd2;
   localparam logic [31:0] S_SWAP   = 32'd3;
   localparam logic [31:0] S_SETTLE = 32'd4;

   logic       clk;
   logic       rst_n;
   logic [2:0] state_dbg;
   int         n_cmp;
   int         n_fail;
   int         swap_seen;
   int         s0;

   vram_swap_if #(.MISS_W(8)) bus ();

   vram_swap_ctrl #(
      .WINDOW_CYCLES(64),
      .SETTLE_CYCLES(4),
      .MISS_W(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .state_dbg (state_dbg)
   );

   // Clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count swap strobes on the falling edge, away from state updates.
   initial swap_seen = 0;
   always @(negedge clk) if (bus.swap === 1'b1) swap_seen = swap_seen + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp = n_cmp + 1;
      assert (obs === exp) else begin
         n_fail = n_fail + 1;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_vblank();
      bus.vblank_start = 1'b1;
      step(1);
      bus.vblank_start = 1'b0;
   endtask

   task automatic pulse_req();
      bus.sync_req = 1'b1;
      step(1);
      bus.sync_req = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_swap"},    32'(bus.swap),         32'd0);
      chk({tag, "_block"},   32'(bus.cpu_wr_block), 32'd0);
      chk({tag, "_pending"}, 32'(bus.sync_pending), 32'd0);
      chk({tag, "_done"},    32'(bus.sync_done),    32'd0);
      chk({tag, "_missed"},  32'(bus.missed_cnt),   32'd0);
      chk({tag, "_state"},   32'(state_dbg),        S_IDLE);
   endtask

   initial begin
      n_cmp  = 0;
      n_fail = 0;
      rst_n  = 1'b0;
      bus.vblank_start = 1'b0;
      bus.sync_req     = 1'b0;
      bus.auto_swap_en = 1'b0;
      bus.cpu_wr_busy  = 1'b0;
      step(3);
      chk_all_zero("reset");
      rst_n = 1'b1;
      step(1);

      // Basic CPU-requested swap, writer idle
      pulse_req();
      chk("t1_state_armed", 32'(state_dbg),        S_ARMED);
      chk("t1_pending",     32'(bus.sync_pending), 32'd1);
      chk("t1_block_off",   32'(bus.cpu_wr_block), 32'd0);
      step(8);
      pulse_vblank();
      chk("t1_win_state",   32'(state_dbg),        S_WINDOW);
      chk("t1_win_block",   32'(bus.cpu_wr_block), 32'd1);
      chk("t1_win_noswap",  32'(bus.swap),         32'd0);
      step(1);
      chk("t1_swap",        32'(bus.swap),         32'd1);
      chk("t1_swap_block",  32'(bus.cpu_wr_block), 32'd1);
      chk("t1_swap_pend",   32'(bus.sync_pending), 32'd0);
      chk("t1_swap_nodone", 32'(bus.sync_done),    32'd0);
      step(1);
      chk("t1_done",        32'(bus.sync_done),    32'd1);
      chk("t1_done_noswap", 32'(bus.swap),         32'd0);
      chk("t1_done_block",  32'(bus.cpu_wr_block), 32'd1);
      step(3);
      chk("t1_settle_last", 32'(state_dbg),        S_SETTLE);
      chk("t1_last_block",  32'(bus.cpu_wr_block), 32'd1);
      chk("t1_last_nodone", 32'(bus.sync_done),    32'd0);
      step(1);
      chk("t1_idle",        32'(state_dbg),        S_IDLE);
      chk("t1_unblock",     32'(bus.cpu_wr_block), 32'd0);
      chk("t1_missed",      32'(bus.missed_cnt),   32'd0);
      chk("t1_swaps",       32'(swap_seen),        32'd1);

      // Window expiry with the writer stuck busy
      s0 = swap_seen;
      pulse_req();
      bus.cpu_wr_busy = 1'b1;
      pulse_vblank();
      step(63);
      chk("t2_win_end_state", 32'(state_dbg),        S_WINDOW);
      chk("t2_win_end_block", 32'(bus.cpu_wr_block), 32'd1);
      step(1);
      chk("t2_rearmed",     32'(state_dbg),        S_ARMED);
      chk("t2_unblock",     32'(bus.cpu_wr_block), 32'd0);
      chk("t2_missed",      32'(bus.missed_cnt),   32'd1);
      chk("t2_pending",     32'(bus.sync_pending), 32'd1);
      step(35);
      chk("t2_noswap",      32'(swap_seen),        32'(s0));
      bus.cpu_wr_busy = 1'b0;
      step(5);
      pulse_vblank();
      chk("t2_lat1_noswap", 32'(bus.swap),         32'd0);
      step(1);
      chk("t2_swap",        32'(bus.swap),         32'd1);
      step(5);
      chk("t2_idle",        32'(state_dbg),        S_IDLE);
      chk("t2_missed_hold", 32'(bus.missed_cnt),   32'd1);
      chk("t2_swaps",       32'(swap_seen),        32'(s0 + 1));

      // Auto swap on three vblanks
      s0 = swap_seen;
      bus.auto_swap_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         chk("t3_idle_pend",  32'(bus.sync_pending), 32'd0);
         pulse_vblank();
         chk("t3_win_pend",   32'(bus.sync_pending), 32'd1);
         chk("t3_win_noswap", 32'(bus.swap),         32'd0);
         step(1);
         chk("t3_swap",       32'(bus.swap),         32'd1);
         step(998);
      end
      bus.auto_swap_en = 1'b0;
      chk("t3_swaps",       32'(swap_seen),        32'(s0 + 3));
      chk("t3_idle",        32'(state_dbg),        S_IDLE);

      // Merged requests, then a request during SETTLE
      s0 = swap_seen;
      repeat (5) begin
         pulse_req();
         step(3);
      end
      chk("t4_armed",       32'(state_dbg),        S_ARMED);
      pulse_vblank();
      step(1);
      chk("t4_swap",        32'(bus.swap),         32'd1);
      step(1);
      pulse_req();
      step(3);
      chk("t4_rearm_state", 32'(state_dbg),        S_ARMED);
      chk("t4_rearm_pend",  32'(bus.sync_pending), 32'd1);
      chk("t4_rearm_block", 32'(bus.cpu_wr_block), 32'd0);
      step(20);
      chk("t4_one_swap",    32'(swap_seen),        32'(s0 + 1));
      pulse_vblank();
      step(1);
      chk("t4_swap2",       32'(bus.swap),         32'd1);
      step(5);
      chk("t4_idle",        32'(state_dbg),        S_IDLE);
      chk("t4_two_swaps",   32'(swap_seen),        32'(s0 + 2));

      // Asynchronous reset inside WINDOW and inside SETTLE
      pulse_req();
      bus.cpu_wr_busy = 1'b1;
      pulse_vblank();
      step(3);
      chk("t5_in_window",   32'(state_dbg),        S_WINDOW);
      rst_n = 1'b0;
      #1;
      chk_all_zero("t5_rst_win");
      step(1);
      rst_n = 1'b1;
      bus.cpu_wr_busy = 1'b0;
      step(1);
      pulse_req();
      pulse_vblank();
      step(2);
      chk("t5_in_settle",   32'(state_dbg),        S_SETTLE);
      step(1);
      rst_n = 1'b0;
      #1;
      chk_all_zero("t5_rst_settle");
      step(1);
      rst_n = 1'b1;
      step(1);
      s0 = swap_seen;
      pulse_vblank();
      step(10);
      chk("t5_no_swap",     32'(swap_seen),        32'(s0));
      chk("t5_idle",        32'(state_dbg),        S_IDLE);

      // Saturating missed-frame counter
      pulse_req();
      bus.cpu_wr_busy = 1'b1;
      for (int i = 1; i <= 300; i++) begin
         pulse_vblank();
         step(64);
         if (i == 1)   chk("t6_miss_1",   32'(bus.missed_cnt), 32'd1);
         if (i == 254) chk("t6_miss_254", 32'(bus.missed_cnt), 32'd254);
         if (i == 255) chk("t6_miss_255", 32'(bus.missed_cnt), 32'd255);
         if (i == 256) chk("t6_miss_sat", 32'(bus.missed_cnt), 32'd255);
      end
      chk("t6_miss_final",  32'(bus.missed_cnt),   32'd255);
      chk("t6_state",       32'(state_dbg),        S_ARMED);
      bus.cpu_wr_busy = 1'b0;
      step(2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/vram_swap_ctrl.md
Name: vram_swap_ctrl

Overview:
- Generates the one-cycle `swap` strobe for the double-buffered VRAM, which toggles ownership of its two banks between PPU and CPU.
- Latches CPU sync requests, or auto-requests every frame, and issues the swap only inside a bounded window after vblank start, once the CPU-side write path has drained.
- Fences CPU VRAM writes around the swap so no write lands in the bank being handed to the PPU.
- Sits directly upstream of the VRAM swap input; driven by the HPS/CPU register block and the video timing generator.

Parameters:
- WINDOW_CYCLES, 64, max cycles after vblank_start to wait for cpu_wr_busy low before deferring to the next frame (>=1).
- SETTLE_CYCLES, 4, cycles cpu_wr_block stays high after the swap cycle (>=1).
- MISS_W, 8, width of the saturating missed-frame counter.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- vblank_start  input  1  one-cycle pulse at the first cycle of vblank.
- sync_req  input  1  one-cycle CPU request for a swap at the next vblank.
- auto_swap_en  input  1  level; when high, a request is generated internally at every vblank_start.
- cpu_wr_busy  input  1  level; CPU VRAM writer has an outstanding write.
- swap  output  1  one-cycle swap strobe to VRAM.
- cpu_wr_block  output  1  CPU writer must not start new VRAM writes while high.
- sync_pending  output  1  request latched, swap not yet issued.
- sync_done  output  1  one-cycle pulse, the cycle after swap goes high.
- missed_cnt  output  MISS_W  saturating count of vblank windows that expired with a request pending.

Behaviour:
- Async reset (rst_n low, any cycle including mid-sequence) -> state IDLE, counters 0, all outputs 0. No swap is ever emitted on the reset edge.
- FSM states: IDLE, ARMED, WINDOW, SWAP, SETTLE.
- IDLE:
  - sync_req -> ARMED.
  - vblank_start with auto_swap_en=1, or with sync_req in the same cycle -> WINDOW directly; win_cnt loads 0.
- ARMED: sync_pending=1. vblank_start -> WINDOW, win_cnt=0.
- WINDOW:
  - sync_pending=1, cpu_wr_block=1; win_cnt increments each cycle.
  - cpu_wr_busy=0 -> SWAP next cycle. The first cycle of WINDOW counts, so the minimum latency is vblank_start -> swap = 2 cycles.
  - If win_cnt reaches WINDOW_CYCLES-1 with busy still high -> ARMED; missed_cnt += 1, saturating at all-ones; cpu_wr_block drops next cycle.
- SWAP: swap=1 and cpu_wr_block=1 for exactly one cycle -> SETTLE, set_cnt=0. sync_pending drops in this cycle.
- SETTLE:
  - cpu_wr_block=1; sync_done=1 on its first cycle only.
  - After SETTLE_CYCLES cycles -> IDLE.
  - A sync_req arriving during SWAP/SETTLE is latched in a sticky flag; exit goes to ARMED instead of IDLE.
- Requests arriving while ARMED/WINDOW are merged; there is never more than one swap per vblank.
- vblank_start while in WINDOW/SWAP/SETTLE is ignored.
- Exception: auto_swap_en with vblank_start in SETTLE sets the sticky flag.
- Outputs are registered except swap, sync_done and sync_pending, which are Moore-decoded from state with no input feed-through.
- Throughput: at most one swap per vblank_start.

Test Plan:
- Reset, then sync_req at t0, vblank_start at t10, cpu_wr_busy=0 -> swap high at t12 only; sync_done at t13; cpu_wr_block high t11..t12+SETTLE_CYCLES (t16 with default 4); missed_cnt=0.
- sync_req, vblank_start, cpu_wr_busy held high 100 cycles with WINDOW_CYCLES=64 -> no swap; missed_cnt=1; state ARMED; cpu_wr_block low after 64 window cycles. Busy low before the next vblank_start -> swap 2 cycles after that pulse.
- auto_swap_en=1, three vblank_start pulses 1000 cycles apart, busy=0 -> exactly three swap pulses, each 2 cycles after its vblank_start; sync_pending never high outside WINDOW.
- sync_req pulsed 5 times between two vblanks -> exactly one swap. sync_req during SETTLE -> second swap at the following vblank.
- rst_n asserted during WINDOW and during SETTLE -> all outputs 0 immediately. A later vblank_start with no request -> no swap.
- Force 300 window expiries with MISS_W=8 -> missed_cnt saturates at 255.
